cpu_cycle_sequencer: RTL

Generates the T-state and M-cycle timing for the control unit and owns the instruction register. It drives the one-hot `Cycle_Step`, `Cycle_Count` and X/Y/Z/P/Q decode buses consumed by the X0–X3 microcode groups. It closes each instruction on their OR-ed `Fetch` request by latching the next opcode from the data bus. It sits between the memory bus interface and the per-group microcode decoders, and is the only sequential element in the control path.

---
 rtl/cpu_cycle_sequencer_if.sv | 27 ++
 rtl/cpu_cycle_sequencer.sv | 53 +++++
 2 files changed

// File: rtl/cpu_cycle_sequencer_if.sv
// cpu_cycle_sequencer_if: bus between the memory interface / microcode groups and the cycle sequencer
interface cpu_cycle_sequencer_if;
   logic       i_Hold;
   logic       i_Fetch;
   logic [7:0] i_Data_Bus;
   logic [3:0] o_Cycle_Step;
   logic [7:0] o_Cycle_Count;
   logic [7:0] o_Opcode;
   logic [3:0] o_X;
   logic [7:0] o_Y;
   logic [7:0] o_Z;
   logic [3:0] o_P;
   logic [1:0] o_Q;
   logic       o_CB_Prefix;
   logic       o_Instr_Start;
   logic       o_Fault;
   modport slave (
      input  i_Hold, i_Fetch, i_Data_Bus,
      output o_Cycle_Step, o_Cycle_Count, o_Opcode, o_X, o_Y, o_Z, o_P, o_Q,
             o_CB_Prefix, o_Instr_Start, o_Fault
   );
   modport master (
      output i_Hold, i_Fetch, i_Data_Bus,
      input  o_Cycle_Step, o_Cycle_Count, o_Opcode, o_X, o_Y, o_Z, o_P, o_Q,
             o_CB_Prefix, o_Instr_Start, o_Fault
   );
endinterface

// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: T-state/M-cycle timing, instruction register and one-hot opcode decode
module cpu_cycle_sequencer (
   input logic                  i_Clk,
   input logic                  i_Reset,
   cpu_cycle_sequencer_if.slave bus
);
   logic [3:0] r_step, w_step_nx;
   logic [7:0] r_count, w_count_nx;
   logic [7:0] r_opcode, w_opcode_nx;
   logic       r_cb, w_cb_nx;
   logic       r_start, w_start_nx;
   logic       r_fault, w_fault_nx;
   logic       w_load, w_adv;
   always_comb begin
      w_load      = r_step[3] & bus.i_Fetch & ~bus.i_Hold;
      w_adv       = r_step[3] & ~bus.i_Fetch & ~bus.i_Hold;
      w_step_nx   = bus.i_Hold ? r_step : {r_step[2:0], r_step[3]};
      w_count_nx  = w_load ? 8'h01 : (w_adv & ~r_count[7]) ? {r_count[6:0], 1'b0} : r_count;
      w_opcode_nx = w_load ? bus.i_Data_Bus : r_opcode;
      // a CB fetched as the second byte of a prefixed opcode must not re-arm the prefix
      w_cb_nx     = w_load ? (bus.i_Data_Bus == 8'hCB) & ~r_cb : r_cb;
      w_start_nx  = bus.i_Hold ? r_start : w_load;
      w_fault_nx  = r_fault | (w_adv & r_count[7]);
   end
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_step   <= 4'b0001;
         r_count  <= 8'h01;
         r_opcode <= 8'h00;
         r_cb     <= 1'b0;
         r_start  <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_step   <= w_step_nx;
         r_count  <= w_count_nx;
         r_opcode <= w_opcode_nx;
         r_cb     <= w_cb_nx;
         r_start  <= w_start_nx;
         r_fault  <= w_fault_nx;
      end
   end
   assign bus.o_Cycle_Step  = r_step;
   assign bus.o_Cycle_Count = r_count;
   assign bus.o_Opcode      = r_opcode;
   assign bus.o_X           = 4'(1) << r_opcode[7:6];
   assign bus.o_Y           = 8'(1) << r_opcode[5:3];
   assign bus.o_Z           = 8'(1) << r_opcode[2:0];
   assign bus.o_P           = 4'(1) << r_opcode[5:4];
   assign bus.o_Q           = 2'(1) << r_opcode[3];
   assign bus.o_CB_Prefix   = r_cb;
   assign bus.o_Instr_Start = r_start;
   assign bus.o_Fault       = r_fault;
endmodule
